// File: rtl/loopyV_data_types.sv
// Shared types and constants for the data-memory responder.
package loopyV_data_types;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned CNT_W    = 64;
    localparam int unsigned LANES    = XLEN / 8;

    // Byte offsets inside the 16-byte peripheral window.
    localparam logic [3:0] MMIO_GPIO   = 4'h0;
    localparam logic [3:0] MMIO_CNT_LO = 4'h4;
    localparam logic [3:0] MMIO_CNT_HI = 4'h8;
    localparam logic [3:0] MMIO_STATUS = 4'hC;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_MMIO,
        REGION_NONE
    } regionType;

    // One data-bus request as presented by the core in a cycle.
    typedef struct packed {
        logic [XLEN-1:0]  addr;
        logic             readEn;
        logic             writeEn;
        logic [LANES-1:0] writeMask;
        logic [XLEN-1:0]  writeData;
    } dataBusReq;

    // Merge the enabled byte lanes of newWord into oldWord.
    function automatic logic [XLEN-1:0] applyMask(
        input logic [XLEN-1:0]  oldWord,
        input logic [XLEN-1:0]  newWord,
        input logic [LANES-1:0] mask
    );
        logic [XLEN-1:0] merged;
        merged = oldWord;
        for (int i = 0; i < int'(LANES); i++) begin
            if (mask[i]) merged[8*i +: 8] = newWord[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dm_ram_bank.sv
// Word-organised RAM with byte-lane writes and a registered read port.
// Contents are deliberately not reset so a vendor macro can drop in.
module dm_ram_bank
    import loopyV_data_types::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           writeEn,
    input  logic [LANES-1:0]               writeMask,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [XLEN-1:0]                writeData,
    input  logic                           readEn,
    output logic [XLEN-1:0]                readData
);

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    // Read returns the pre-write word when read and write share an edge.
    always_ff @(posedge clk) begin
        if (readEn) readData <= mem[addr];
        if (writeEn) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (writeMask[i]) mem[addr][8*i +: 8] <= writeData[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Data-bus responder: RAM, GPIO/cycle-counter/status peripherals, error flag.
module dm_responder
    import loopyV_data_types::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  dataBusAddr,
    input  logic             dataBusReadEn,
    input  logic             dataBusWriteEn,
    input  logic [LANES-1:0] dataBusWriteMask,
    input  logic [XLEN-1:0]  dataBusWriteData,
    output logic [XLEN-1:0]  dataBusReadData,
    output logic [XLEN-1:0]  gpioOut,
    output logic             busError
);

    localparam int unsigned ADDR_W    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

    dataBusReq        req;
    regionType        region;
    regionType        rdRegion;
    logic [3:0]       mmioOff;
    logic             reqValid;
    logic             ramWe;
    logic             ramRe;
    logic             gpioWe;
    logic             errSet;
    logic             errClr;
    logic [XLEN-1:0]  ramRdData;
    logic [XLEN-1:0]  mmioRdValue;
    logic [XLEN-1:0]  mmioRdData;
    logic [CNT_W-1:0] counter;
    logic [XLEN-1:0]  shadow;

    assign req = '{
        addr:      dataBusAddr,
        readEn:    dataBusReadEn,
        writeEn:   dataBusWriteEn,
        writeMask: dataBusWriteMask,
        writeData: dataBusWriteData
    };

    // Requests seen while reset is high are dropped, including RAM writes.
    assign reqValid = ~reset;
    assign mmioOff  = {req.addr[3:2], 2'b00};

    // Address decode; RAM takes priority should the windows ever overlap.
    always_comb begin
        region = REGION_NONE;
        if ({1'b0, req.addr} < RAM_BYTES) begin
            region = REGION_RAM;
        end else if (req.addr[31:4] == MMIO_BASE[31:4]) begin
            region = REGION_MMIO;
        end
    end

    // Per-target strobes for this cycle's request.
    always_comb begin
        ramWe  = reqValid && req.writeEn && (region == REGION_RAM);
        ramRe  = reqValid && req.readEn  && (region == REGION_RAM);
        gpioWe = reqValid && req.writeEn && (region == REGION_MMIO)
                 && (mmioOff == MMIO_GPIO);
        errClr = reqValid && req.writeEn && (region == REGION_MMIO)
                 && (mmioOff == MMIO_STATUS)
                 && req.writeMask[0] && req.writeData[0];
        errSet = reqValid && (req.readEn || req.writeEn) && (region == REGION_NONE);
    end

    dm_ram_bank #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ramBank (
        .clk       (clk),
        .writeEn   (ramWe),
        .writeMask (req.writeMask),
        .addr      (req.addr[ADDR_W+1:2]),
        .writeData (req.writeData),
        .readEn    (ramRe),
        .readData  (ramRdData)
    );

    // Peripheral read value, sampled before any same-edge update.
    always_comb begin
        mmioRdValue = '0;
        case (mmioOff)
            MMIO_GPIO:   mmioRdValue = gpioOut;
            MMIO_CNT_LO: mmioRdValue = counter[XLEN-1:0];
            MMIO_CNT_HI: mmioRdValue = shadow;
            MMIO_STATUS: mmioRdValue = {31'b0, busError};
            default:     mmioRdValue = '0;
        endcase
    end

    // Counter, shadow, GPIO, status and read-source tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter    <= '0;
            shadow     <= '0;
            gpioOut    <= '0;
            busError   <= 1'b0;
            rdRegion   <= REGION_NONE;
            mmioRdData <= '0;
        end else begin
            counter <= counter + 64'd1;
            if (req.readEn) begin
                rdRegion   <= region;
                mmioRdData <= mmioRdValue;
                if ((region == REGION_MMIO) && (mmioOff == MMIO_CNT_LO)) begin
                    shadow <= counter[CNT_W-1:XLEN];
                end
            end
            if (gpioWe) gpioOut <= applyMask(gpioOut, req.writeData, req.writeMask);
            if (errSet) begin
                busError <= 1'b1;
            end else if (errClr) begin
                busError <= 1'b0;
            end
        end
    end

    // Read data is steered by the region captured with the last read;
    // unmapped reads and the reset state both yield zero.
    always_comb begin
        dataBusReadData = '0;
        case (rdRegion)
            REGION_RAM:  dataBusReadData = ramRdData;
            REGION_MMIO: dataBusReadData = mmioRdData;
            default:     dataBusReadData = '0;
        endcase
    end

endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit RAM words, power of two.
REQ-002 The block SHALL have parameter MMIO_BASE, default 32'h8000_0000: base of the 16-byte peripheral window, 16-byte aligned.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port dataBusAddr, input, 32 bits: byte address from the core.
REQ-006 The block SHALL have port dataBusReadEn, input, 1 bit: read request this cycle.
REQ-007 The block SHALL have port dataBusWriteEn, input, 1 bit: write request this cycle.
REQ-008 The block SHALL have port dataBusWriteMask, input, 4 bits: byte-lane write enables.
REQ-009 The block SHALL have port dataBusWriteData, input, 32 bits: lane-aligned store data.
REQ-010 The block SHALL have port dataBusReadData, output, 32 bits: registered read data.
REQ-011 The block SHALL have port gpioOut, output, 32 bits: GPIO register value.
REQ-012 The block SHALL have port busError, output, 1 bit: sticky out-of-range access flag.

Function
REQ-013 Address decode SHALL be: RAM when dataBusAddr < DEPTH_WORDS*4; MMIO when dataBusAddr[31:4] == MMIO_BASE[31:4]; all other addresses are unmapped.
REQ-014 Word index SHALL be dataBusAddr[log2(DEPTH_WORDS)+1:2]; dataBusAddr[1:0] SHALL be ignored for selection.
REQ-015 A write SHALL update only the byte lanes whose dataBusWriteMask bit is 1, at the clock edge of the request cycle.
REQ-016 Read latency SHALL be exactly 1 cycle: dataBusReadData is the full addressed word, unshifted, in the cycle after dataBusReadEn=1.
REQ-017 dataBusReadData SHALL hold its value in every cycle with dataBusReadEn=0.
REQ-018 When dataBusReadEn and dataBusWriteEn are both 1 at the same address, the write SHALL occur and the read SHALL return the pre-write word (read-before-write).
REQ-019 MMIO offset 0x0 (GPIO) SHALL be read/write with byte masking, and gpioOut SHALL equal this register.
REQ-020 A free-running 64-bit cycle counter SHALL increment by 1 every cycle and wrap from all-ones to 0.
REQ-021 MMIO offset 0x4 SHALL read counter[31:0] and, in the same cycle, latch counter[63:32] into a shadow register.
REQ-022 MMIO offset 0x8 SHALL read the shadow register, not the live upper half.
REQ-023 Writes to MMIO offsets 0x4 and 0x8 SHALL be ignored.
REQ-024 MMIO offset 0xC SHALL read {31'b0, busError}; a write with mask[0]=1 and data[0]=1 SHALL clear busError.
REQ-025 An unmapped read SHALL return 32'h0; an unmapped write SHALL change no state.
REQ-026 Any unmapped read or write SHALL set busError on the next edge.
REQ-027 When a clear and a set of busError coincide, set SHALL win.
REQ-028 A write with dataBusWriteMask=4'b0000 SHALL be a no-op but SHALL still set busError if unmapped.

Reset
REQ-029 While reset=1, the block SHALL hold dataBusReadData=0, gpioOut=0, busError=0, counter=0 and shadow=0, independent of clk.
REQ-030 RAM contents SHALL NOT be reset.
REQ-031 A request presented in a cycle where reset is asserted SHALL be discarded.
REQ-032 The counter SHALL read 1 at the first edge after reset deasserts.

Structure
REQ-033 MMIO offsets (GPIO=0x0, CNT_LO=0x4, CNT_HI=0x8, STATUS=0xC) and a region enum {REGION_RAM, REGION_MMIO, REGION_NONE} SHALL reside in loopyV_data_types.
REQ-034 The RAM array SHALL be a sub-module dm_ram_bank (byte-masked write, registered read), so that it can later be swapped for a vendor macro.
REQ-035 Decode, MMIO registers and read-data muxing SHALL be in dm_responder.

Verification
REQ-036 Write 32'hDEADBEEF to 0x10 with mask 4'b1111, then read 0x10 -> dataBusReadData=32'hDEADBEEF exactly one cycle later.
REQ-037 Write 32'h0000AA00 to 0x10 with mask 4'b0010 over 32'hDEADBEEF, then read 0x10 -> 32'hDEADAAEF.
REQ-038 Read and write to 0x20 in the same cycle (old 32'h1, new 32'h2) -> read returns 32'h1, and the next read returns 32'h2.
REQ-039 Preload counter to 32'hFFFF_FFFF in the low half, read 0x8000_0004 then 0x8000_0008 -> the high read equals the upper half at the time of the low read.
REQ-040 Read 0x4000_0000 -> data 0 and busError=1; write 1 to 0x8000_000C -> busError=0; an unmapped access in the same cycle as the clear -> busError stays 1.
REQ-041 Assert reset mid-read, with GPIO=32'h5 -> all outputs 0 asynchronously, and RAM data written earlier still readable afterwards.
